// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one mem_controller request port between NUM_REQ FWFT FIFOs.
// Define MEM_ARB_FIXED_PRIO_EN to switch to fixed priority (lowest non-empty index wins).
module mem_req_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SRC_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 31,
  parameter int unsigned TID_WIDTH     = 16,
  parameter int unsigned REQ_WIDTH     = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int unsigned DP_DATA_WIDTH = TID_WIDTH + REQ_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_empty,
  input  logic [NUM_REQ*DP_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_rd_en,
  output logic                             mc_empty,
  output logic [DP_DATA_WIDTH-1:0]         mc_data,
  input  logic                             mc_rd,
  output logic [SRC_WIDTH-1:0]             grant_src
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                     state_q, state_d;
  logic [DP_DATA_WIDTH-1:0]   mc_data_q, mc_data_d;
  logic [SRC_WIDTH-1:0]       grant_src_q, grant_src_d;
  logic [SRC_WIDTH-1:0]       gnt_idx;
  logic                       gnt_valid;
  logic [DP_DATA_WIDTH-1:0]   head;
  logic                       load;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest non-empty index is the final write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (!req_empty[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_WIDTH'(i);
      end
    end
  end
`else
  logic [SRC_WIDTH-1:0] last_ptr_q, last_ptr_d;
  logic [SRC_WIDTH:0]   scan;

  // Scan offsets NUM_REQ..1 so the nearest requester after last_ptr is the final write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan = {1'b0, last_ptr_q} + (SRC_WIDTH + 1)'(k);
      if (scan >= (SRC_WIDTH + 1)'(NUM_REQ)) begin
        scan = scan - (SRC_WIDTH + 1)'(NUM_REQ);
      end
      if (!req_empty[scan[SRC_WIDTH-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan[SRC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    last_ptr_d = last_ptr_q;
    if (reset && load && gnt_valid) begin
      last_ptr_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_ptr_q <= SRC_WIDTH'(NUM_REQ - 1);
    end else begin
      last_ptr_q <= last_ptr_d;
    end
  end
`endif

  always_comb begin
    head = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == SRC_WIDTH'(i)) begin
        head = req_data[i*DP_DATA_WIDTH +: DP_DATA_WIDTH];
      end
    end
  end

  assign load = (state_q == StEmpty) || mc_rd;

  always_comb begin
    state_d     = state_q;
    mc_data_d   = mc_data_q;
    grant_src_d = grant_src_q;
    req_rd_en   = '0;
    // Pops are suppressed while reset is asserted so no FIFO entry is lost.
    if (reset && load) begin
      if (gnt_valid) begin
        req_rd_en[gnt_idx]                           = 1'b1;
        mc_data_d                                    = head;
        mc_data_d[DP_DATA_WIDTH-1 -: SRC_WIDTH]      = gnt_idx;
        grant_src_d                                  = gnt_idx;
        state_d                                      = StFull;
      end else begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StEmpty;
      mc_data_q   <= '0;
      grant_src_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_data_q   <= mc_data_d;
      grant_src_q <= grant_src_d;
    end
  end

  assign mc_empty  = (state_q == StEmpty);
  assign mc_data   = mc_data_q;
  assign grant_src = grant_src_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: FIFOs held as queues, expected grants derived from the arbitration rule.
// Honours MEM_ARB_FIXED_PRIO_EN the same way as the design.
module tb_mem_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;
  localparam int TID_W   = 16;
  localparam int REQ_W   = 1 + 31 + 32;
  localparam int DP      = TID_W + REQ_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_empty;
  logic [NUM_REQ*DP-1:0]   req_data;
  logic [NUM_REQ-1:0]      req_rd_en;
  logic                    mc_empty;
  logic [DP-1:0]           mc_data;
  logic                    mc_rd;
  logic [SRC_W-1:0]        grant_src;

  mem_req_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_empty (req_empty),
    .req_data  (req_data),
    .req_rd_en (req_rd_en),
    .mc_empty  (mc_empty),
    .mc_data   (mc_data),
    .mc_rd     (mc_rd),
    .grant_src (grant_src)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Requester FIFOs and the reference view of the output register.
  logic [DP-1:0] q [NUM_REQ][$];
  bit            m_full = 1'b0;
  logic [DP-1:0] m_data = '0;
  int            m_src  = 0;
  int            m_last = NUM_REQ - 1;
  logic [DP-1:0] t3_exp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DP-1:0] rand_entry();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DP-1:0];
  endfunction

  function automatic logic [DP-1:0] tag_entry(input logic [DP-1:0] e, input int g);
    int            tid;
    int            span;
    logic [DP-1:0] o;
    span = 1 << (TID_W - SRC_W);
    tid  = int'(e[DP-1 -: TID_W]);
    tid  = (tid % span) + g * span;
    o    = e;
    o[DP-1 -: TID_W] = 16'(tid);
    return o;
  endfunction

  // Winner per the arbitration rule; -1 when nobody is requesting.
  function automatic int pick();
    int g = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (g < 0 && q[i].size() > 0) g = i;
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i = (m_last + k) % NUM_REQ;
      if (g < 0 && q[i].size() > 0) g = i;
    end
`endif
    return g;
  endfunction

  task automatic step(input bit rst_n, input bit rd);
    int                 g;
    logic [NUM_REQ-1:0] exp_rd;
    @(negedge clk);
    reset = rst_n;
    mc_rd = rd;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_empty[i] = (q[i].size() == 0);
      req_data[i*DP +: DP] = (q[i].size() > 0) ? q[i][0] : rand_entry();
    end
    #1;
    g = (rst_n && (!m_full || rd)) ? pick() : -1;
    exp_rd = '0;
    if (g >= 0) exp_rd[g] = 1'b1;
    chk("req_rd_en", 128'(req_rd_en), 128'(exp_rd));
    chk("mc_empty",  128'(mc_empty),  128'(!m_full));
    chk("mc_data",   128'(mc_data),   128'(m_data));
    chk("grant_src", 128'(grant_src), 128'(m_src));
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0; m_data = '0; m_src = 0; m_last = NUM_REQ - 1;
    end else if (g >= 0) begin
      m_data = tag_entry(q[g].pop_front(), g);
      m_src  = g;
      m_full = 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
      m_last = g;
`endif
    end else if (m_full && rd) begin
      m_full = 1'b0;
    end
  endtask

  task automatic fill(input int i, input int n);
    for (int k = 0; k < n; k++) q[i].push_back(rand_entry());
  endtask

  initial begin
    reset = 1'b0;
    mc_rd = 1'b0;
    req_empty = '1;
    req_data = '0;

    // T1: reset held with every FIFO loaded; first grant goes to requester 0.
    for (int i = 0; i < NUM_REQ; i++) fill(i, 3);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    #1;
    chk("t1_first_grant", 128'(grant_src), 128'(0));
    chk("t1_not_empty",   128'(mc_empty),  128'(0));

    // T2: continuous consumption with all requesters busy.
    for (int i = 0; i < NUM_REQ; i++) fill(i, 6);
    for (int c = 0; c < 12; c++) step(1'b1, 1'b1);

    // T3: single requester 2, TID tagging.
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    t3_exp = rand_entry();
    t3_exp[DP-1 -: TID_W] = 16'h1234;
    q[2].push_back(t3_exp);
    t3_exp[DP-1 -: TID_W] = 16'h9234;
    step(1'b1, 1'b0);
    #1;
    chk("t3_tid",   128'(mc_data[DP-1 -: TID_W]), 128'(16'h9234));
    chk("t3_src",   128'(grant_src),              128'(2));
    chk("t3_body",  128'(mc_data[REQ_W-1:0]),     128'(t3_exp[REQ_W-1:0]));

    // T4: stall with others pending.
    fill(0, 2); fill(1, 2); fill(3, 2);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
    #1;
    chk("t4_hold", 128'(mc_data), 128'(t3_exp));

    // T5: reset pulse while full drops the held entry without popping.
    step(1'b0, 1'b0);
    #1;
    chk("t5_empty", 128'(mc_empty), 128'(1));
    chk("t5_q0_kept", 128'(q[0].size()), 128'(2));
    step(1'b1, 1'b0);

    // T6: requesters 0 and 3 kept busy.
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    for (int c = 0; c < 10; c++) begin
      if (q[0].size() < 2) fill(0, 2);
      if (q[3].size() < 2) fill(3, 2);
      step(1'b1, 1'b1);
`ifdef MEM_ARB_FIXED_PRIO_EN
      if (c > 1) chk("t6_fixed_src", 128'(grant_src), 128'(0));
`endif
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q[i].size() < 5 && $urandom_range(0, 2) == 0) fill(i, 1);
      end
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
